// File: rtl/freq_ring_bank.sv
// Double-banked frequency-index ring sequencer with an AXI4-Lite control slave.
// Software fills the shadow bank while the active bank streams; banks swap at the ring wrap.
module freq_ring_bank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int IDX_WIDTH          = 14,
  parameter int DEPTH_LOG2         = 10
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            rd_en_ring,
  output logic [IDX_WIDTH-1:0]            dout_ring,
  output logic                            dout_valid,
  output logic                            ring_wrap
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LENGTH = 3'd1;
  localparam logic [2:0] REG_WDATA  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_RDPTR  = 3'd4;

  function automatic logic [PW-1:0] clamp_len(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    if (v == {PW{1'b0}}) begin
      r = PW'(1'b1);
    end else if (v > DEPTH_P) begin
      r = DEPTH_P;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [IDX_WIDTH-1:0] mem0_q [DEPTH];
  logic [IDX_WIDTH-1:0] mem1_q [DEPTH];

  logic                  awready_q, awready_d, bvalid_q, bvalid_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  enable_q, enable_d, active_q, active_d;
  logic                  pending_q, pending_d, ovf_q, ovf_d, busyerr_q, busyerr_d;
  logic [PW-1:0]         length_q, length_d, len_active_q, len_active_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_WIDTH-1:0]  dout_q, dout_d;
  logic                  dvalid_q, dvalid_d, wrap_q, wrap_d;

  logic [2:0]            waddr_s, raddr_s;
  logic                  wr_fire_s, rd_fire_s;
  logic                  ctrl_wr_s, len_wr_s, wdat_wr_s, stat_wr_s;
  logic                  accept_s, last_s, swap_done_s, full_s, wd_ok_s;
  logic [IDX_WIDTH-1:0]  rd_word_s;
  logic [31:0]           status_s;
  logic                  unused_s;

  assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_WDATA,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign waddr_s   = S_AXI_AWADDR[4:2];
  assign raddr_s   = S_AXI_ARADDR[4:2];
  assign wr_fire_s = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire_s = arready_q & S_AXI_ARVALID;
  assign ctrl_wr_s = wr_fire_s & (waddr_s == REG_CTRL);
  assign len_wr_s  = wr_fire_s & (waddr_s == REG_LENGTH);
  assign wdat_wr_s = wr_fire_s & (waddr_s == REG_WDATA);
  assign stat_wr_s = wr_fire_s & (waddr_s == REG_STATUS);

  assign accept_s    = enable_q & rd_en_ring;
  assign last_s      = ({1'b0, rd_ptr_q} == (len_active_q - PW'(1'b1)));
  // A pending swap lands on the last-entry accept or whenever the ring is disabled.
  assign swap_done_s = pending_q & (~enable_q | (accept_s & last_s));
  assign full_s      = (wr_ptr_q == DEPTH_P);
  assign wd_ok_s     = wdat_wr_s & ~pending_q & ~full_s;
  assign rd_word_s   = active_q ? mem1_q[rd_ptr_q] : mem0_q[rd_ptr_q];

  // Register read mux and status word assembly.
  always_comb begin
    status_s              = 32'd0;
    status_s[16 +: PW]    = wr_ptr_q;
    status_s[3:0]         = {busyerr_q, ovf_q, pending_q, active_q};
    case (raddr_s)
      REG_CTRL:   rdata_d = {31'd0, enable_q};
      REG_LENGTH: rdata_d = 32'(length_q);
      REG_STATUS: rdata_d = status_s;
      REG_RDPTR:  rdata_d = 32'(rd_ptr_q);
      default:    rdata_d = 32'd0;
    endcase
  end

  // Next-state logic for the AXI handshakes, control registers and ring datapath.
  always_comb begin
    awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;

    if (wr_fire_s) begin
      bvalid_d = 1'b1;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    if (rd_fire_s) begin
      rvalid_d = 1'b1;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    enable_d = ctrl_wr_s ? S_AXI_WDATA[0] : enable_q;
    length_d = len_wr_s ? S_AXI_WDATA[PW-1:0] : length_q;

    // A SWAP request arriving in the completion cycle re-arms for the next wrap.
    if (ctrl_wr_s && S_AXI_WDATA[1]) begin
      pending_d = 1'b1;
    end else if (swap_done_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (swap_done_s) begin
      active_d     = ~active_q;
      len_active_d = clamp_len(length_q);
    end else begin
      active_d     = active_q;
      len_active_d = len_active_q;
    end

    if (swap_done_s || (ctrl_wr_s && S_AXI_WDATA[2])) begin
      wr_ptr_d = {PW{1'b0}};
    end else if (wd_ok_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (wdat_wr_s && !pending_q && full_s) begin
      ovf_d = 1'b1;
    end else if (stat_wr_s && S_AXI_WDATA[2]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (wdat_wr_s && pending_q) begin
      busyerr_d = 1'b1;
    end else if (stat_wr_s && S_AXI_WDATA[3]) begin
      busyerr_d = 1'b0;
    end else begin
      busyerr_d = busyerr_q;
    end

    if (!enable_q) begin
      rd_ptr_d = {DEPTH_LOG2{1'b0}};
    end else if (accept_s) begin
      rd_ptr_d = last_s ? {DEPTH_LOG2{1'b0}} : rd_ptr_q + DEPTH_LOG2'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    dout_d   = accept_s ? rd_word_s : dout_q;
    dvalid_d = accept_s;
    wrap_d   = accept_s & last_s;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      enable_q     <= 1'b0;
      active_q     <= 1'b0;
      pending_q    <= 1'b0;
      ovf_q        <= 1'b0;
      busyerr_q    <= 1'b0;
      length_q     <= PW'(1'b1);
      len_active_q <= PW'(1'b1);
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {DEPTH_LOG2{1'b0}};
      dout_q       <= {IDX_WIDTH{1'b0}};
      dvalid_q     <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rd_fire_s ? rdata_d : rdata_q;
      enable_q     <= enable_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      busyerr_q    <= busyerr_d;
      length_q     <= length_d;
      len_active_q <= len_active_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dout_q       <= dout_d;
      dvalid_q     <= dvalid_d;
      wrap_q       <= wrap_d;
    end
  end

  // Shadow-bank write port; bank contents are deliberately not reset.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wd_ok_s) begin
      if (active_q) begin
        mem0_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= S_AXI_WDATA[IDX_WIDTH-1:0];
      end else begin
        mem1_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= S_AXI_WDATA[IDX_WIDTH-1:0];
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign dout_ring     = dout_q;
  assign dout_valid    = dvalid_q;
  assign ring_wrap     = wrap_q;

endmodule
